// File: rtl/hack_exec_ctrl_if.sv
// Bus bundle between the Hack execution controller and its ROM, RAM and ALU.
// The master modport is the controller; the slave modport is the memory/ALU side.
interface hack_exec_ctrl_if;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_req;
  logic [14:0] pc;
  logic [15:0] in_m;
  logic        in_m_valid;
  logic        read_m;
  logic        write_m;
  logic [15:0] out_m;
  logic [14:0] address_m;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        zx, nx, zy, ny, f, no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    input  instr, instr_valid, in_m, in_m_valid, alu_out, alu_zr, alu_ng,
    output instr_req, pc, read_m, write_m, out_m, address_m, alu_x, alu_y,
           zx, nx, zy, ny, f, no
  );

  modport slave (
    output instr, instr_valid, in_m, in_m_valid, alu_out, alu_zr, alu_ng,
    input  instr_req, pc, read_m, write_m, out_m, address_m, alu_x, alu_y,
           zx, nx, zy, ny, f, no
  );
endinterface

// File: rtl/hack_exec_ctrl.sv
// Multi-cycle Hack execution controller: FETCH/DECODE/MEMRD/EXEC around an external ALU.
// Define HACK_HALT_DETECT_EN to add the HALT state that traps tight jump-to-self loops.
module hack_exec_ctrl (
  input  logic             clk,
  input  logic             rst_n,
  hack_exec_ctrl_if.master bus,
  output logic             halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEMRD,
    S_EXEC
`ifdef HACK_HALT_DETECT_EN
    , S_HALT
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mr_q, mr_d;
  logic        instr_req_q, instr_req_d;
  logic        read_m_q, read_m_d;
  logic        write_m_q, write_m_d;
  logic [14:0] pc_inc;
  logic        jump_taken;
`ifdef HACK_HALT_DETECT_EN
  logic        halted_q, halted_d;
  logic        halt_loop;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    a_d       = a_q;
    d_d       = d_q;
    ir_d      = ir_q;
    mr_d      = mr_q;
`ifdef HACK_HALT_DETECT_EN
    halted_d  = halted_q;
    halt_loop = (a_q[14:0] == pc_q) || (a_q[14:0] == pc_q - 15'd1);
`endif
    pc_inc     = pc_q + 15'd1;
    jump_taken = (ir_q[2] & bus.alu_ng) | (ir_q[1] & bus.alu_zr) |
                 (ir_q[0] & ~bus.alu_ng & ~bus.alu_zr);

    case (state_q)
      S_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[15]) begin
          a_d     = {1'b0, ir_q[14:0]};
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          state_d = ir_q[12] ? S_MEMRD : S_EXEC;
        end
      end
      S_MEMRD: begin
        if (bus.in_m_valid) begin
          mr_d    = bus.in_m;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Jump target and write address both come from a_q, i.e. A before this update.
        if (ir_q[5]) a_d = bus.alu_out;
        if (ir_q[4]) d_d = bus.alu_out;
        pc_d    = jump_taken ? a_q[14:0] : pc_inc;
        state_d = S_FETCH;
`ifdef HACK_HALT_DETECT_EN
        if (jump_taken && halt_loop) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end
`endif
      end
`ifdef HACK_HALT_DETECT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase

    // Strobes are registered from the next state so they are glitch-free and align with it.
    instr_req_d = (state_d == S_FETCH);
    read_m_d    = (state_d == S_MEMRD);
    write_m_d   = (state_d == S_EXEC) && ir_q[3];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      a_q         <= '0;
      d_q         <= '0;
      ir_q        <= '0;
      mr_q        <= '0;
      instr_req_q <= 1'b1;
      read_m_q    <= 1'b0;
      write_m_q   <= 1'b0;
`ifdef HACK_HALT_DETECT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      a_q         <= a_d;
      d_q         <= d_d;
      ir_q        <= ir_d;
      mr_q        <= mr_d;
      instr_req_q <= instr_req_d;
      read_m_q    <= read_m_d;
      write_m_q   <= write_m_d;
`ifdef HACK_HALT_DETECT_EN
      halted_q    <= halted_d;
`endif
    end
  end

  assign bus.instr_req = instr_req_q;
  assign bus.pc        = pc_q;
  assign bus.read_m    = read_m_q;
  assign bus.write_m   = write_m_q;
  assign bus.out_m     = bus.alu_out;
  assign bus.address_m = a_q[14:0];
  assign bus.alu_x     = d_q;
  assign bus.alu_y     = ir_q[12] ? mr_q : a_q;
  assign {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ir_q[11:6];

`ifdef HACK_HALT_DETECT_EN
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_hack_exec_ctrl.sv
// Self-checking bench for hack_exec_ctrl: ROM/RAM/ALU environment, an instruction-level
// Hack model feeding a scoreboard of completions and memory writes.
module tb_hack_exec_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted;

  always #5 clk = ~clk;

  hack_exec_ctrl_if bus ();

  hack_exec_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus.master),
    .halted (halted)
  );

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, r;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    r = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) r = ~r;
    return r;
  endfunction

  assign bus.alu_out = hack_alu(bus.alu_x, bus.alu_y,
                                {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no});
  assign bus.alu_zr  = (bus.alu_out == 16'h0000);
  assign bus.alu_ng  = bus.alu_out[15];

  logic [15:0] rom   [0:32767];
  logic [15:0] ram   [0:32767];
  logic [15:0] m_ram [0:32767];

  typedef struct packed {
    logic [14:0] pc;
    logic [15:0] a;
    logic [15:0] d;
  } done_t;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];

  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  bit          m_halted;

  int errors = 0;
  int checks = 0;
  int issued, issue_limit;
  int rom_wait, ram_wait, rom_cnt, ram_cnt;
  int read_cycles, write_cycles;
  bit prev_req;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
  endtask

  task automatic model_exec(input logic [15:0] ins);
    logic [15:0] y, r, old_a;
    logic [14:0] pc_c;
    logic        zr, ng, taken;
    check("fetch_pc", 32'(bus.pc), 32'(m_pc));
    pc_c = m_pc;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = pc_c + 15'd1;
      done_q.push_back('{pc: m_pc, a: m_a, d: m_d});
    end else begin
      y     = ins[12] ? m_ram[m_a[14:0]] : m_a;
      r     = hack_alu(m_d, y, ins[11:6]);
      zr    = (r == 16'h0000);
      ng    = r[15];
      taken = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
      old_a = m_a;
      if (ins[3]) begin
        m_ram[old_a[14:0]] = r;
        wr_q.push_back('{addr: old_a[14:0], data: r});
      end
      if (ins[5]) m_a = r;
      if (ins[4]) m_d = r;
      m_pc = taken ? old_a[14:0] : pc_c + 15'd1;
`ifdef HACK_HALT_DETECT_EN
      if (taken && (old_a[14:0] == pc_c || old_a[14:0] == pc_c - 15'd1)) m_halted = 1'b1;
      else
`endif
      done_q.push_back('{pc: m_pc, a: m_a, d: m_d});
    end
  endtask

  // Called at a falling edge: observe the DUT, then drive ROM/RAM for the next rising edge.
  task automatic sample_and_drive();
    done_t e;
    wr_t   w;
    if (bus.instr_req && !prev_req) begin
      check("done_pending", 32'(done_q.size() > 0), 32'd1);
      if (done_q.size() > 0) begin
        e = done_q.pop_front();
        check("pc", 32'(bus.pc), 32'(e.pc));
        check("a_reg", 32'(bus.address_m), 32'(e.a[14:0]));
        check("d_reg", 32'(bus.alu_x), 32'(e.d));
      end
    end
    if (bus.write_m) begin
      write_cycles++;
      check("wr_pending", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        check("wr_addr", 32'(bus.address_m), 32'(w.addr));
        check("wr_data", 32'(bus.out_m), 32'(w.data));
      end
      ram[bus.address_m] = bus.out_m;
    end
    if (bus.read_m) read_cycles++;
    prev_req = bus.instr_req;

    bus.instr_valid = 1'b0;
    if (bus.instr_req && issued < issue_limit) begin
      if (rom_cnt < rom_wait) rom_cnt++;
      else begin
        rom_cnt         = 0;
        bus.instr       = rom[bus.pc];
        bus.instr_valid = 1'b1;
        issued++;
        model_exec(rom[bus.pc]);
      end
    end

    bus.in_m_valid = 1'b0;
    if (bus.read_m) begin
      if (ram_cnt < ram_wait) ram_cnt++;
      else begin
        ram_cnt        = 0;
        bus.in_m       = ram[bus.address_m];
        bus.in_m_valid = 1'b1;
      end
    end else begin
      ram_cnt = 0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_and_drive();
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.in_m_valid  = 1'b0;
    bus.instr       = 16'h0000;
    bus.in_m        = 16'h0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 32768; i++) begin
      ram[i]   = 16'(i * 7);
      m_ram[i] = 16'(i * 7);
    end
    done_q.delete();
    wr_q.delete();
    m_a = '0; m_d = '0; m_pc = '0; m_halted = 1'b0;
    issued = 0; issue_limit = 0;
    rom_wait = 0; ram_wait = 0; rom_cnt = 0; ram_cnt = 0;
    read_cycles = 0; write_cycles = 0;
    prev_req = 1'b1;
    rst_n = 1'b1;
  endtask

  // Issue instructions up to a total count and wait for all expectations to drain.
  task automatic run(input int limit, input int budget);
    bit finished;
    finished    = 1'b0;
    issue_limit = limit;
    sample_and_drive();
    for (int i = 0; i < budget && !finished; i++) begin
      tick();
      finished = (issued >= issue_limit) && (done_q.size() == 0) && (wr_q.size() == 0);
    end
    check("run_done", 32'(finished), 32'd1);
  endtask

  initial begin
    bit seen;
    clear_rom();

    // Reset values, then an asynchronous reset landing in the middle of an M-write.
    do_reset();
    check("rst_pc", 32'(bus.pc), 32'd0);
    check("rst_instr_req", 32'(bus.instr_req), 32'd1);
    check("rst_read_m", 32'(bus.read_m), 32'd0);
    check("rst_write_m", 32'(bus.write_m), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_a", 32'(bus.address_m), 32'd0);
    check("rst_d", 32'(bus.alu_x), 32'd0);

    rom[0] = 16'h0064; rom[1] = 16'hE7C8;
    issue_limit = 2;
    seen = 1'b0;
    sample_and_drive();
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = bus.write_m;
    end
    check("abort_saw_write", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_write_m", 32'(bus.write_m), 32'd0);
    check("abort_read_m", 32'(bus.read_m), 32'd0);
    do_reset();
    check("abort_pc", 32'(bus.pc), 32'd0);
    check("abort_instr_req", 32'(bus.instr_req), 32'd1);
    check("abort_a", 32'(bus.address_m), 32'd0);
    check("abort_d", 32'(bus.alu_x), 32'd0);

    // Register load with zero-wait ROM: D=21, pc=2 after five cycles.
    clear_rom();
    rom[0] = 16'h0015; rom[1] = 16'hEC10;
    issue_limit = 2;
    sample_and_drive();
    repeat (4) tick();
    check("exec_ctrl", 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}), 32'b110000);
    check("exec_no_write", 32'(bus.write_m), 32'd0);
    tick();
    check("load_pc", 32'(bus.pc), 32'd2);
    check("load_d", 32'(bus.alu_x), 32'd21);
    check("load_drained", 32'(done_q.size()), 32'd0);

    // Memory write M=D+1 at A=100.
    do_reset();
    clear_rom();
    rom[0] = 16'h0015; rom[1] = 16'hEC10; rom[2] = 16'h0064; rom[3] = 16'hE7C8;
    run(4, 60);
    check("mw_write_cycles", 32'(write_cycles), 32'd1);
    check("mw_ram100", 32'(ram[100]), 32'd22);

    // Memory read D=M with two RAM wait cycles.
    do_reset();
    clear_rom();
    ram[100] = 16'h1234; m_ram[100] = 16'h1234;
    rom[0] = 16'h0064; rom[1] = 16'hFC10;
    ram_wait = 2;
    run(2, 60);
    check("mr_read_cycles", 32'(read_cycles), 32'd3);
    check("mr_d", 32'(bus.alu_x), 32'h1234);

    // Jumps with a slow ROM: JEQ taken, JGT not taken, AM=D;JMP uses the old A.
    do_reset();
    clear_rom();
    rom[0]  = 16'h0000; rom[1]  = 16'hEC10; rom[2]  = 16'h0032; rom[3]  = 16'hE302;
    rom[50] = 16'hEE90; rom[51] = 16'hE301; rom[52] = 16'h0005; rom[53] = 16'hEC10;
    rom[54] = 16'h003C; rom[55] = 16'hE32F;
    rom_wait = 1;
    run(10, 300);
    check("jmp_pc", 32'(bus.pc), 32'd60);
    check("jmp_a_new", 32'(bus.address_m), 32'd5);
    check("jmp_ram60", 32'(ram[60]), 32'd5);

    // 15-bit pc wrap after the top address.
    do_reset();
    clear_rom();
    rom[0] = 16'h7FFF; rom[1] = 16'hEA87; rom[32767] = 16'h0003;
    run(3, 60);
    check("wrap_pc", 32'(bus.pc), 32'd0);
    check("wrap_a", 32'(bus.address_m), 32'd3);

    // Tight loop at pc 7/8.
    do_reset();
    clear_rom();
    rom[0] = 16'h0007; rom[1] = 16'hEA87; rom[7] = 16'h0007; rom[8] = 16'hEA87;
`ifdef HACK_HALT_DETECT_EN
    run(4, 100);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_instr_req", 32'(bus.instr_req), 32'd0);
      check("halt_flag", 32'(halted), 32'(m_halted));
    end
    do_reset();
    check("halt_cleared", 32'(halted), 32'd0);
`else
    run(10, 200);
    check("loop_pc", 32'(bus.pc), 32'd7);
    check("loop_halted", 32'(halted), 32'(m_halted));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hack_exec_ctrl.md
# hack_exec_ctrl

Multi-cycle Hack-ISA execution controller sitting directly upstream of the `alu` block. It fetches 16-bit instructions, holds the A and D registers, PC and IR, and drives the ALU operands and the six control bits `zx nx zy ny f no`. It consumes the ALU result and the `zr`/`ng` flags to perform register and memory writeback and jump resolution. Instruction ROM and data RAM sit behind valid-qualified request interfaces.

## Interface
- No parameters: widths fixed at 16-bit data and 15-bit addresses.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 16: ROM read data.
- `instr_valid` in 1: `instr` valid this cycle.
- `instr_req` out 1: fetch request for address `pc`.
- `pc` out 15: instruction address.
- `in_m` in 16: RAM read data.
- `in_m_valid` in 1: `in_m` valid this cycle.
- `read_m` out 1: RAM read request at `address_m`.
- `write_m` out 1: one-cycle RAM write strobe.
- `out_m` out 16: RAM write data; equals `alu_out`.
- `address_m` out 15: RAM address; always the A register.
- `alu_x`, `alu_y` out 16: ALU operands.
- `zx`, `nx`, `zy`, `ny`, `f`, `no` out 1: ALU controls, equal to IR[11:6].
- `alu_out` in 16, `alu_zr` in 1, `alu_ng` in 1: ALU result and flags.
- `halted` out 1: halt-loop detected. Tied to 0 unless `HACK_HALT_DETECT_EN` is defined.

## Operation
- States: FETCH, DECODE, MEMRD, EXEC, HALT (HALT exists only with the macro).
- FETCH:
  - `instr_req`=1 with `pc` stable.
  - On `instr_valid`, IR<=`instr`, go to DECODE.
  - Without `instr_valid`, stay in FETCH.
- DECODE, A-instruction (IR[15]=0):
  - A<=IR[14:0], pc<=pc+1, go to FETCH.
- DECODE, C-instruction (IR[15]=1; IR[14:13] ignored):
  - a-bit IR[12]=1: go to MEMRD.
  - a-bit IR[12]=0: go to EXEC.
- MEMRD:
  - `read_m`=1 until `in_m_valid`.
  - On `in_m_valid`, MR<=`in_m`, go to EXEC.
- Operand drive (all states): `alu_x`=D; `alu_y`=IR[12] ? MR : A.
- EXEC:
  - Result sampled at the clock edge that ends EXEC.
  - IR[5]: A<=`alu_out`.
  - IR[4]: D<=`alu_out`.
  - IR[3]: `write_m`=1 during EXEC, with `address_m` = old A.
- Jump, resolved in EXEC:
  - taken = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr).
  - Taken: pc<=old A. Not taken: pc<=pc+1.
  - Then go to FETCH.
- Simultaneous A-destination and jump or M-write: jump target and write address both use A *before* the update.
- pc arithmetic is 15-bit: 0x7FFF+1 wraps to 0x0000.

## Timing
- Reset values: pc=0, A=0, D=0, IR=0, MR=0, state=FETCH, `instr_req`=1, `read_m`=0, `write_m`=0, `halted`=0.
- Reset is asynchronous. Asserting `rst_n` mid-instruction drops `write_m` and `read_m` immediately and aborts the instruction; no partial writeback occurs.
- Minimum latencies with zero-wait memories:
  - A-instruction: 2 cycles.
  - C-instruction without M: 3 cycles.
  - C-instruction with M: 4 cycles.
  - Each ROM or RAM wait cycle adds one cycle.
- `write_m` is high exactly one cycle per M-destination instruction and never in any other state.
- `instr_valid` outside FETCH and `in_m_valid` outside MEMRD are ignored.

## Configuration
- `HACK_HALT_DETECT_EN` defined:
  - A taken jump in EXEC whose target equals the C-instruction's pc or pc-1 (15-bit wrap) sets `halted`=1 and enters HALT.
  - HALT has `instr_req`=0 and no further state changes.
  - Only reset clears it.
- `HACK_HALT_DETECT_EN` undefined:
  - HALT state absent; `halted` is constant 0.
  - The jump executes normally and loops indefinitely.

## Test plan
- Reset: hold `rst_n`=0 mid-EXEC of an M-write -> `write_m` drops immediately. After release: pc=0, `instr_req`=1, A=D=0.
- Register load, zero-wait ROM: 0x0015 then 0xEC10 (D=A) -> controls 110000 in EXEC, D=21, pc=2 after 5 cycles.
- Memory write: A=100, D=21, then 0xE7C8 (M=D+1) -> `write_m` high for 1 cycle with `address_m`=100, `out_m`=22.
- Memory read with wait: A=100, then 0xFC10 (D=M), `in_m`=0x1234 valid 3 cycles late -> `read_m` high 3 cycles, D=0x1234.
- Jump resolution:
  - D=0, A=50, then 0xE302 (D;JEQ) -> pc=50.
  - D=0xFFFF, then 0xE301 (D;JGT) -> pc increments.
  - AM=D with a jump -> target is the old A.
- With macro: 0x0007 at pc 7, then 0xEA87 (0;JMP) at pc 8 -> `halted`=1, `instr_req` stays 0 until reset. Without macro -> pc alternates 7,8 indefinitely.
